// File: rtl/ram_8bit_pkg.sv
// ram_8bit_pkg
// Shared defaults and word/address types for the 64 x 8 scratch RAM.
//   DATA_W : word width in bits
//   ADDR_W : address width in bits
//   DEPTH  : number of words (2**ADDR_W by default)
package ram_8bit_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/ram_8bit_if.sv
// ram_8bit_if
// Bundle between a RAM user and the bare storage array: one write port
// (wr_data/wr_addr/wr_en) and one combinational read port (rd_addr/rd_data).
//   master : drives the write port and the read address, receives rd_data
//   slave  : the storage side
interface ram_8bit_if #(
    parameter int DATA_W = ram_8bit_pkg::DATA_W,
    parameter int ADDR_W = ram_8bit_pkg::ADDR_W
);
    import ram_8bit_pkg::*;

    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output wr_data,
        output wr_addr,
        output wr_en,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_data,
        input  wr_addr,
        input  wr_en,
        input  rd_addr,
        output rd_data
    );

endinterface

// File: rtl/ram_8bit_array.sv
// ram_8bit_array
// Bare storage: DEPTH words of DATA_W bits, synchronous write, combinational
// read. No reset on the array so it maps onto block or distributed RAM.
//   clk  : rising-edge clock
//   port : ram_8bit_if slave (write port + read port)
module ram_8bit_array #(
    parameter int DATA_W = ram_8bit_pkg::DATA_W,
    parameter int ADDR_W = ram_8bit_pkg::ADDR_W,
    parameter int DEPTH  = ram_8bit_pkg::DEPTH
) (
    input logic          clk,
    ram_8bit_if.slave    port
);
    import ram_8bit_pkg::*;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (port.wr_en) begin
            mem[port.wr_addr] <= port.wr_data;
        end
    end

    assign port.rd_data = mem[port.rd_addr];

endmodule

// File: rtl/ram_8bit_core.sv
// ram_8bit_core
// Single-port 64 x 8 RAM with a registered read address. q shows the word at
// the address captured on the previous rising edge; a write is visible on q
// right after its capturing edge when addr is held.
//   data  : write data
//   addr  : read/write address
//   we    : write enable, active-high
//   clk   : rising-edge clock
//   q     : read data (0 until the first edge after reset release)
//   rst_n : asynchronous active-low reset (clears addr_reg/rd_valid only)
module ram_8bit_core #(
    parameter int DATA_W = ram_8bit_pkg::DATA_W,
    parameter int ADDR_W = ram_8bit_pkg::ADDR_W,
    parameter int DEPTH  = ram_8bit_pkg::DEPTH
) (
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic              clk,
    output logic [DATA_W-1:0] q,
    input  logic              rst_n
);
    import ram_8bit_pkg::*;

    // One extra bit so DEPTH == 2**ADDR_W is representable in the compare.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] addr_reg;
    logic              rd_valid;
    logic              wr_in_range;
    logic              rd_in_range;

    ram_8bit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) arr_bus ();

    assign wr_in_range = ({1'b0, addr} < DEPTH_L);
    assign rd_in_range = ({1'b0, addr_reg} < DEPTH_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg <= '0;
            rd_valid <= 1'b0;
        end else begin
            addr_reg <= addr;
            rd_valid <= 1'b1;
        end
    end

    // The array has no reset, so a write is blocked while rst_n is low to
    // keep a reset that lands mid-write from corrupting memory.
    assign arr_bus.wr_data = data;
    assign arr_bus.wr_addr = addr;
    assign arr_bus.wr_en   = we & rst_n & wr_in_range;
    assign arr_bus.rd_addr = addr_reg;

    ram_8bit_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk  (clk),
        .port (arr_bus.slave)
    );

    assign q = (rd_valid && rd_in_range) ? arr_bus.rd_data : '0;

endmodule

// File: tb/tb_ram_8bit_core.sv
module tb_ram_8bit_core;
    import ram_8bit_pkg::*;

    logic clk;
    logic rst_n;
    word_t q;

    ram_8bit_if bus ();

    // Single-port part: the read address is the same bus address.
    assign bus.rd_addr = bus.wr_addr;

    ram_8bit_core dut (
        .data  (bus.wr_data),
        .addr  (bus.wr_addr),
        .we    (bus.wr_en),
        .clk   (clk),
        .q     (q),
        .rst_n (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what the RAM holds and which address q is showing.
    word_t mem_m   [DEPTH];
    bit    known_m [DEPTH];
    int    show_m;
    bit    valid_m;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input word_t got, input word_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: q=%02h expected %02h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (rst_n) begin
            if (bus.wr_en) begin
                mem_m[int'(bus.wr_addr)]   = bus.wr_data;
                known_m[int'(bus.wr_addr)] = 1'b1;
            end
            show_m  = int'(bus.wr_addr);
            valid_m = 1'b1;
        end
    endtask

    task automatic model_reset();
        show_m  = 0;
        valid_m = 1'b0;
    endtask

    task automatic check_model(input string tag);
        if (!valid_m)
            check_eq(tag, q, 8'h00);
        else if (known_m[show_m])
            check_eq(tag, q, mem_m[show_m]);
    endtask

    // One clock: model sees the inputs at the edge, q sampled 1 time unit later.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic drive(input bit w, input int a, input word_t d);
        bus.wr_en   = w;
        bus.wr_addr = addr_t'(a);
        bus.wr_data = d;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            known_m[i] = 1'b0;
            mem_m[i]   = 8'h00;
        end
        model_reset();
        rst_n = 1'b0;
        drive(0, 0, 8'h00);
        #1;
        check_eq("reset_q", q, 8'h00);
        #2;
        rst_n = 1'b1;

        // Write burst
        drive(1, 0, 8'h01); step("wr0");
        check_eq("wr0_q", q, 8'h01);
        drive(1, 1, 8'h06); step("wr1");
        drive(1, 2, 8'h02); step("wr2");
        drive(1, 3, 8'h04); step("wr3");
        check_eq("wr3_q", q, 8'h04);

        drive(0, 0, 8'h00); step("rd0"); check_eq("rd0_q", q, 8'h01);
        drive(0, 1, 8'h00); step("rd1"); check_eq("rd1_q", q, 8'h06);
        drive(0, 2, 8'h00); step("rd2"); check_eq("rd2_q", q, 8'h02);

        // Write after read
        drive(1, 4, 8'h09); step("wr4"); check_eq("wr4_q", q, 8'h09);
        drive(0, 3, 8'h00); step("rd3"); check_eq("rd3_q", q, 8'h04);

        // Read during write, same address
        drive(1, 5, 8'hAA); step("rdw_a"); check_eq("rdw_aa", q, 8'hAA);
        drive(1, 5, 8'h55); step("rdw_b"); check_eq("rdw_55", q, 8'h55);

        // Async reset mid-cycle, with a write attempted across a held-reset edge
        drive(0, 5, 8'h00);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("rst_mid_q", q, 8'h00);
        drive(1, 3, 8'h77);
        step("rst_hold");
        check_eq("rst_hold_q", q, 8'h00);
        #2;
        rst_n = 1'b1;
        drive(0, 1, 8'h00); step("post_rst1"); check_eq("post_rst1_q", q, 8'h06);
        drive(0, 3, 8'h00); step("post_rst3"); check_eq("post_rst3_q", q, 8'h04);

        // Write-enable gating
        for (int i = 0; i < 4; i++) begin
            drive(0, 2, 8'hFF);
            step("we_gate");
            check_eq("we_gate_q", q, 8'h02);
        end

        // Address extremes
        drive(1, 63, 8'hC3); step("wr63");
        drive(1, 0, 8'h3C);  step("wr00");
        drive(0, 63, 8'h00); step("rd63"); check_eq("rd63_q", q, 8'hC3);
        drive(0, 0, 8'h00);  step("rd00"); check_eq("rd00_q", q, 8'h3C);

        // Randomized traffic against the reference array
        for (int i = 0; i < 1000; i++) begin
            drive($urandom_range(0, 1) == 1, int'($urandom_range(0, DEPTH - 1)),
                  word_t'($urandom_range(0, 255)));
            step("rand");
            if ($urandom_range(0, 49) == 0) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                check_eq("rand_rst", q, 8'h00);
                rst_n = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
